// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
//
// Shares one physical SRAM port between two requesters:
//   requester 0 : SLC-3 CPU memory path (MAR/MDR accesses)
//   requester 1 : program loader / debug port
//
// Three jobs: round-robin arbitration, fixed wait-state sequencing of the
// active-low OE/WE strobes, and read-data capture with a one-cycle ack.
//
// Handshake: a requester raises req (level) together with we/addr/wdata and
// holds req until it sees its ack pulse.  we/addr/wdata are sampled only on
// the IDLE cycle in which the request wins; later changes are ignored.  The
// requester drops req on the edge at which it observes ack; a req still high
// in the following IDLE cycle is a new request.
//
// Parameters
//   WAIT_CYCLES    extra SRAM access cycles beyond the first (0..7)
//
// Ports
//   Clk, Reset                 clock, synchronous active-high reset
//   cpu_req/we/addr/wdata      CPU request, type (1=write), address, data
//   cpu_ack                    one-cycle CPU completion pulse
//   ld_req/we/addr/wdata       loader request, same rules as CPU
//   ld_ack                     one-cycle loader completion pulse
//   rdata                      data from the most recent completed read
//   ADDR, Data_to_SRAM         SRAM address and write data
//   Data_from_SRAM             SRAM read data
//   OE, WE                     SRAM strobes, active low
//   busy                       high whenever the FSM is not IDLE
//   grant                      one-hot owner: 01 = CPU, 10 = loader
//   o_dbg_state                current FSM state (IDLE=0, ACCESS=1, DONE=2)
// ---------------------------------------------------------------------------
module sram_arbiter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  input  logic        ld_req,
  input  logic        ld_we,
  input  logic [15:0] ld_addr,
  input  logic [15:0] ld_wdata,
  output logic        ld_ack,
  output logic [15:0] rdata,
  output logic [15:0] ADDR,
  output logic [15:0] Data_to_SRAM,
  input  logic [15:0] Data_from_SRAM,
  output logic        OE,
  output logic        WE,
  output logic        busy,
  output logic [1:0]  grant,
  output logic [1:0]  o_dbg_state
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // Counter load value; WAIT_CYCLES is only meaningful in 0..7.
  localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

  logic [1:0]  r_state;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic        r_we;
  logic [1:0]  r_grant;
  logic        r_last_ld;   // 1 when the loader owned the previous transfer
  logic [2:0]  r_cnt;
  logic [15:0] r_rdata;

  logic        w_cpu_wins;
  logic        w_ld_wins;
  logic        w_in_access;
  logic        w_in_done;

  // Arbitration: a lone request wins; on a tie the requester that did not
  // own the previous transfer wins.  The two terms are mutually exclusive.
  assign w_cpu_wins = cpu_req & (~ld_req  | r_last_ld);
  assign w_ld_wins  = ld_req  & (~cpu_req | ~r_last_ld);

  assign w_in_access = (r_state == ST_ACCESS);
  assign w_in_done   = (r_state == ST_DONE);

  // Every output comes from registered state; nothing from req reaches a pin
  // combinationally.
  assign ADDR         = r_addr;
  assign Data_to_SRAM = r_wdata;
  assign OE           = ~(w_in_access & ~r_we);
  assign WE           = ~(w_in_access &  r_we);
  assign cpu_ack      = w_in_done & r_grant[0];
  assign ld_ack       = w_in_done & r_grant[1];
  assign rdata        = r_rdata;
  assign busy         = (r_state != ST_IDLE);
  assign grant        = r_grant;
  assign o_dbg_state  = r_state;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_we      <= 1'b0;
      r_grant   <= 2'b00;
      r_last_ld <= 1'b1;      // CPU wins the first tie after reset
      r_cnt     <= '0;
      r_rdata   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cpu_wins || w_ld_wins) begin
            r_addr    <= w_ld_wins ? ld_addr  : cpu_addr;
            r_wdata   <= w_ld_wins ? ld_wdata : cpu_wdata;
            r_we      <= w_ld_wins ? ld_we    : cpu_we;
            r_grant   <= {w_ld_wins, w_cpu_wins};
            r_last_ld <= w_ld_wins;
            r_cnt     <= WAIT_INIT;
            r_state   <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // Counter at zero marks the final access cycle; a read captures
          // the SRAM data on that edge.
          if (r_cnt == 3'd0) begin
            if (!r_we) begin
              r_rdata <= Data_from_SRAM;
            end
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        ST_DONE: begin
          r_grant <= 2'b00;
          r_state <= ST_IDLE;
        end
        default: begin
          r_grant <= 2'b00;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_arbiter
//
// Bench for sram_arbiter.  Main instance uses WAIT_CYCLES = 2; a second
// instance uses WAIT_CYCLES = 0.  Inputs change and outputs are sampled on
// the falling clock edge.  The random test is checked against a
// transaction-level model: a memory image updated at completion and
// arbitration timing computed from the latency rules.
// ---------------------------------------------------------------------------
module tb_sram_arbiter;

  localparam int W = 2;

  // clock / reset
  logic Clk;
  logic Reset;
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // main DUT signals
  logic        cpu_req, cpu_we, ld_req, ld_we;
  logic [15:0] cpu_addr, cpu_wdata, ld_addr, ld_wdata;
  logic        cpu_ack, ld_ack, OE, WE, busy;
  logic [15:0] rdata, ADDR, Data_to_SRAM, Data_from_SRAM;
  logic [1:0]  grant, dbg_state;

  // WAIT_CYCLES = 0 DUT signals
  logic        z_cpu_req, z_cpu_we, z_ld_req, z_ld_we;
  logic [15:0] z_cpu_addr, z_cpu_wdata, z_ld_addr, z_ld_wdata;
  logic        z_cpu_ack, z_ld_ack, z_OE, z_WE, z_busy;
  logic [15:0] z_rdata, z_ADDR, z_Data_to_SRAM, z_din;
  logic [1:0]  z_grant, z_dbg_state;

  // SRAM model for the main DUT
  logic [15:0] sram_mem [256] = '{default: 16'h0000};
  logic        ovr_en;
  logic [15:0] ovr_val;

  always @(posedge Clk) begin
    if (!WE) sram_mem[ADDR[7:0]] <= Data_to_SRAM;
  end
  assign Data_from_SRAM = !OE ? (ovr_en ? ovr_val : sram_mem[ADDR[7:0]]) : 16'hDEAD;

  int n_vec;
  int n_err;

  sram_arbiter #(.WAIT_CYCLES(W)) dut (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_ack(ld_ack),
    .rdata(rdata), .ADDR(ADDR), .Data_to_SRAM(Data_to_SRAM),
    .Data_from_SRAM(Data_from_SRAM), .OE(OE), .WE(WE), .busy(busy),
    .grant(grant), .o_dbg_state(dbg_state)
  );

  sram_arbiter #(.WAIT_CYCLES(0)) dut0 (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(z_cpu_req), .cpu_we(z_cpu_we), .cpu_addr(z_cpu_addr), .cpu_wdata(z_cpu_wdata),
    .cpu_ack(z_cpu_ack),
    .ld_req(z_ld_req), .ld_we(z_ld_we), .ld_addr(z_ld_addr), .ld_wdata(z_ld_wdata),
    .ld_ack(z_ld_ack),
    .rdata(z_rdata), .ADDR(z_ADDR), .Data_to_SRAM(z_Data_to_SRAM),
    .Data_from_SRAM(z_din), .OE(z_OE), .WE(z_WE), .busy(z_busy),
    .grant(z_grant), .o_dbg_state(z_dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    cpu_req = 1'b0; ld_req = 1'b0;
    z_cpu_req = 1'b0; z_ld_req = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_vec++;
    if (OE !== 1'b1 || WE !== 1'b1) begin
      n_err++; $display("FAIL reset_strobes OE=%b WE=%b, required 1 1", OE, WE);
    end
    n_vec++;
    if (cpu_ack !== 1'b0 || ld_ack !== 1'b0) begin
      n_err++; $display("FAIL reset_acks cpu_ack=%b ld_ack=%b, required 0 0", cpu_ack, ld_ack);
    end
    n_vec++;
    if (rdata !== 16'h0 || ADDR !== 16'h0 || Data_to_SRAM !== 16'h0) begin
      n_err++;
      $display("FAIL reset_data rdata=%h ADDR=%h DTS=%h, required 0 0 0", rdata, ADDR, Data_to_SRAM);
    end
    n_vec++;
    if (grant !== 2'b00 || busy !== 1'b0) begin
      n_err++; $display("FAIL reset_grant grant=%b busy=%b, required 00 0", grant, busy);
    end
    n_vec++;
    if (z_OE !== 1'b1 || z_WE !== 1'b1 || z_rdata !== 16'h0 || z_grant !== 2'b00) begin
      n_err++;
      $display("FAIL reset_w0 OE=%b WE=%b rdata=%h grant=%b, required 1 1 0 00",
               z_OE, z_WE, z_rdata, z_grant);
    end
  endtask

  task automatic test_cpu_read();
    int oe_low;
    oe_low = 0;
    ovr_en = 1'b1; ovr_val = 16'h1234;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3000; cpu_wdata = 16'h0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge Clk);
      if (OE === 1'b0) oe_low++;
      if (k <= 3) begin
        n_vec++;
        if (OE !== 1'b0 || WE !== 1'b1 || ADDR !== 16'h3000) begin
          n_err++;
          $display("FAIL cpu_read_access k=%0d OE=%b WE=%b ADDR=%h, required 0 1 3000", k, OE, WE, ADDR);
        end
      end
      n_vec++;
      if (cpu_ack !== (k == 4) || ld_ack !== 1'b0) begin
        n_err++;
        $display("FAIL cpu_read_ack k=%0d cpu_ack=%b ld_ack=%b, required %b 0", k, cpu_ack, ld_ack, (k == 4));
      end
      if (k == 4) begin
        n_vec++;
        if (rdata !== 16'h1234) begin
          n_err++; $display("FAIL cpu_read_rdata rdata=%h, required 1234", rdata);
        end
        cpu_req = 1'b0;
      end
    end
    n_vec++;
    if (oe_low != 3) begin
      n_err++; $display("FAIL cpu_read_oe_len cycles=%0d, required 3", oe_low);
    end
  endtask

  task automatic test_loader_write();
    int we_low;
    we_low = 0;
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 16'h0010; ld_wdata = 16'hBEEF;
    for (int k = 1; k <= 6; k++) begin
      @(negedge Clk);
      if (WE === 1'b0) we_low++;
      if (k <= 3) begin
        n_vec++;
        if (WE !== 1'b0 || OE !== 1'b1 || Data_to_SRAM !== 16'hBEEF || ADDR !== 16'h0010) begin
          n_err++;
          $display("FAIL ld_write_access k=%0d WE=%b OE=%b DTS=%h ADDR=%h, required 0 1 beef 0010",
                   k, WE, OE, Data_to_SRAM, ADDR);
        end
      end
      n_vec++;
      if (ld_ack !== (k == 4) || cpu_ack !== 1'b0) begin
        n_err++;
        $display("FAIL ld_write_ack k=%0d ld_ack=%b cpu_ack=%b, required %b 0", k, ld_ack, cpu_ack, (k == 4));
      end
      n_vec++;
      if (rdata !== 16'h1234) begin
        n_err++; $display("FAIL ld_write_rdata k=%0d rdata=%h, required 1234", k, rdata);
      end
      if (k == 4) ld_req = 1'b0;
    end
    n_vec++;
    if (we_low != 3) begin
      n_err++; $display("FAIL ld_write_we_len cycles=%0d, required 3", we_low);
    end
    n_vec++;
    if (sram_mem[8'h10] !== 16'hBEEF) begin
      n_err++; $display("FAIL ld_write_mem mem=%h, required beef", sram_mem[8'h10]);
    end
  endtask

  task automatic test_back_to_back();
    int          gcnt;
    int          gcyc [4];
    logic [1:0]  gown [4];
    logic [1:0]  prev_g;
    logic        cpu_re, ld_re;
    logic [1:0]  exp_own [4];
    exp_own[0] = 2'b01; exp_own[1] = 2'b10; exp_own[2] = 2'b01; exp_own[3] = 2'b10;
    do_reset();
    ovr_en = 1'b1; ovr_val = 16'h0101;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 16'h0200;
    gcnt = 0; prev_g = 2'b00; cpu_re = 1'b0; ld_re = 1'b0;
    for (int i = 0; i < 4; i++) begin gcyc[i] = 0; gown[i] = 2'b00; end
    for (int k = 1; k <= 22; k++) begin
      @(negedge Clk);
      if (grant != 2'b00 && prev_g == 2'b00 && gcnt < 4) begin
        gcyc[gcnt] = k; gown[gcnt] = grant; gcnt++;
      end
      prev_g = grant;
      if (cpu_re) begin cpu_req = (k < 15); cpu_re = 1'b0; end
      if (ld_re)  begin ld_req  = (k < 15); ld_re  = 1'b0; end
      if (cpu_ack === 1'b1) begin cpu_req = 1'b0; cpu_re = 1'b1; end
      if (ld_ack === 1'b1)  begin ld_req  = 1'b0; ld_re  = 1'b1; end
    end
    cpu_req = 1'b0; ld_req = 1'b0;
    n_vec++;
    if (gcnt != 4) begin
      n_err++; $display("FAIL b2b_count grants=%0d, required 4", gcnt);
    end
    n_vec++;
    if (gcyc[0] != 1) begin
      n_err++; $display("FAIL b2b_first cycle=%0d, required 1", gcyc[0]);
    end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (gown[i] !== exp_own[i]) begin
        n_err++; $display("FAIL b2b_owner idx=%0d grant=%b, required %b", i, gown[i], exp_own[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (gcyc[i+1] - gcyc[i] != W + 3) begin
        n_err++;
        $display("FAIL b2b_spacing idx=%0d spacing=%0d, required %0d", i, gcyc[i+1] - gcyc[i], W + 3);
      end
    end
  endtask

  task automatic test_input_change();
    ovr_en = 1'b1; ovr_val = 16'h5555;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3000; cpu_wdata = 16'h0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge Clk);
      if (k <= 4) begin
        n_vec++;
        if (ADDR !== 16'h3000) begin
          n_err++; $display("FAIL addr_hold k=%0d ADDR=%h, required 3000", k, ADDR);
        end
      end
      if (k == 1) begin cpu_addr = 16'h4000; cpu_we = 1'b1; cpu_wdata = 16'hFFFF; end
      if (k == 4) begin
        n_vec++;
        if (cpu_ack !== 1'b1 || rdata !== 16'h5555) begin
          n_err++; $display("FAIL addr_hold_done ack=%b rdata=%h, required 1 5555", cpu_ack, rdata);
        end
        cpu_req = 1'b0; cpu_we = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic saw_ack;
    saw_ack = 1'b0;
    ovr_en = 1'b1; ovr_val = 16'h9999;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3000;
    for (int k = 1; k <= 7; k++) begin
      @(negedge Clk);
      if (cpu_ack === 1'b1 || ld_ack === 1'b1) saw_ack = 1'b1;
      if (k == 2) begin Reset = 1'b1; cpu_req = 1'b0; end
      if (k == 3) begin
        Reset = 1'b0;
        n_vec++;
        if (OE !== 1'b1 || WE !== 1'b1 || grant !== 2'b00 || rdata !== 16'h0 || busy !== 1'b0) begin
          n_err++;
          $display("FAIL reset_mid OE=%b WE=%b grant=%b rdata=%h busy=%b, required 1 1 00 0 0",
                   OE, WE, grant, rdata, busy);
        end
      end
    end
    n_vec++;
    if (saw_ack) begin
      n_err++; $display("FAIL reset_mid_ack saw_ack=1, required 0");
    end
    ovr_val = 16'h7777;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0020;
    for (int k = 1; k <= 6; k++) begin
      @(negedge Clk);
      n_vec++;
      if (cpu_ack !== (k == 4)) begin
        n_err++; $display("FAIL reset_mid_retry k=%0d cpu_ack=%b, required %b", k, cpu_ack, (k == 4));
      end
      if (k == 4) begin
        n_vec++;
        if (rdata !== 16'h7777) begin
          n_err++; $display("FAIL reset_mid_retry_rdata rdata=%h, required 7777", rdata);
        end
        cpu_req = 1'b0;
      end
    end
  endtask

  task automatic test_wait0();
    int          oe_low;
    logic [15:0] cap;
    oe_low = 0; cap = 16'h0;
    z_cpu_req = 1'b1; z_cpu_we = 1'b0; z_cpu_addr = 16'hFFFF; z_cpu_wdata = 16'h0;
    z_din = 16'($urandom);
    for (int k = 1; k <= 4; k++) begin
      @(negedge Clk);
      if (z_OE === 1'b0) oe_low++;
      if (k == 1) begin
        n_vec++;
        if (z_OE !== 1'b0 || z_WE !== 1'b1 || z_ADDR !== 16'hFFFF) begin
          n_err++; $display("FAIL w0_access OE=%b WE=%b ADDR=%h, required 0 1 ffff", z_OE, z_WE, z_ADDR);
        end
      end
      n_vec++;
      if (z_cpu_ack !== (k == 2)) begin
        n_err++; $display("FAIL w0_ack k=%0d ack=%b, required %b", k, z_cpu_ack, (k == 2));
      end
      if (k == 2) begin
        n_vec++;
        if (z_rdata !== cap) begin
          n_err++; $display("FAIL w0_rdata rdata=%h, required %h", z_rdata, cap);
        end
        z_cpu_req = 1'b0;
      end
      z_din = 16'($urandom);
      if (k == 1) cap = z_din;
    end
    n_vec++;
    if (oe_low != 1) begin
      n_err++; $display("FAIL w0_oe_len cycles=%0d, required 1", oe_low);
    end
  endtask

  task automatic test_random();
    logic [15:0] ref_mem [256];
    logic [15:0] exp_rdata;
    logic        rq [2];
    logic        rwe [2];
    logic [15:0] raddr [2];
    logic [15:0] rwd [2];
    int          gap [2];
    int          m_g, m_ack, m_free, m_owner, m_last;
    logic        m_we;
    logic [15:0] m_addr, m_wdata;
    logic        in_acc, in_done;
    logic [1:0]  exp_g;
    int          acks [2];
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0;
    ref_mem[8'h10] = 16'hBEEF;   // written by the loader-write test
    exp_rdata = 16'h0;
    for (int r = 0; r < 2; r++) begin
      rq[r] = 1'b0; rwe[r] = 1'b0; raddr[r] = 16'h0; rwd[r] = 16'h0; gap[r] = 0; acks[r] = 0;
    end
    m_g = -100; m_ack = -100; m_free = 0; m_owner = 0; m_last = 1;
    m_we = 1'b0; m_addr = 16'h0; m_wdata = 16'h0;
    ovr_en = 1'b0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (c > 0) @(negedge Clk);
      in_acc  = (c > m_g) && (c <= m_g + W + 1);
      in_done = (c == m_ack);
      if (in_done) begin
        if (m_we) ref_mem[m_addr[7:0]] = m_wdata;
        else      exp_rdata = ref_mem[m_addr[7:0]];
      end
      exp_g = (in_acc || in_done) ? (m_owner == 1 ? 2'b10 : 2'b01) : 2'b00;
      if (cpu_ack === 1'b1) acks[0]++;
      if (ld_ack === 1'b1)  acks[1]++;
      n_vec++;
      if (cpu_ack !== (in_done && m_owner == 0) || ld_ack !== (in_done && m_owner == 1)) begin
        n_err++;
        $display("FAIL rnd_ack c=%0d cpu=%b ld=%b, required %b %b", c, cpu_ack, ld_ack,
                 (in_done && m_owner == 0), (in_done && m_owner == 1));
      end
      n_vec++;
      if (rdata !== exp_rdata) begin
        n_err++; $display("FAIL rnd_rdata c=%0d rdata=%h, required %h", c, rdata, exp_rdata);
      end
      n_vec++;
      if (grant !== exp_g || busy !== (in_acc || in_done)) begin
        n_err++;
        $display("FAIL rnd_grant c=%0d grant=%b busy=%b, required %b %b", c, grant, busy, exp_g, (in_acc || in_done));
      end
      n_vec++;
      if (OE !== !(in_acc && !m_we) || WE !== !(in_acc && m_we)) begin
        n_err++;
        $display("FAIL rnd_strobe c=%0d OE=%b WE=%b, required %b %b", c, OE, WE,
                 !(in_acc && !m_we), !(in_acc && m_we));
      end
      if (in_acc || in_done) begin
        n_vec++;
        if (ADDR !== m_addr) begin
          n_err++; $display("FAIL rnd_addr c=%0d ADDR=%h, required %h", c, ADDR, m_addr);
        end
      end
      if (in_acc && m_we) begin
        n_vec++;
        if (Data_to_SRAM !== m_wdata) begin
          n_err++; $display("FAIL rnd_wdata c=%0d DTS=%h, required %h", c, Data_to_SRAM, m_wdata);
        end
      end
      // requester behaviour
      for (int r = 0; r < 2; r++) begin
        if (in_done && m_owner == r) begin
          rq[r] = 1'b0;
          gap[r] = $urandom_range(0, 3);
        end else if (!rq[r]) begin
          if (gap[r] > 0) gap[r]--;
          else if ($urandom_range(0, 1) == 1) begin
            rq[r] = 1'b1;
            rwe[r] = 1'($urandom_range(0, 1));
            raddr[r] = 16'($urandom);
            rwd[r] = 16'($urandom);
          end
        end else if (in_acc && m_owner == r) begin
          // scramble inputs of the transfer in flight
          rwe[r] = 1'($urandom_range(0, 1));
          raddr[r] = 16'($urandom);
          rwd[r] = 16'($urandom);
        end
      end
      // arbitration at an idle cycle
      if (c >= m_free && (rq[0] || rq[1])) begin
        if (rq[0] && rq[1]) m_owner = 1 - m_last;
        else                m_owner = rq[1] ? 1 : 0;
        m_last = m_owner;
        m_we = rwe[m_owner]; m_addr = raddr[m_owner]; m_wdata = rwd[m_owner];
        m_g = c; m_ack = c + W + 2; m_free = c + W + 3;
      end
      cpu_req = rq[0]; cpu_we = rwe[0]; cpu_addr = raddr[0]; cpu_wdata = rwd[0];
      ld_req  = rq[1]; ld_we  = rwe[1]; ld_addr  = raddr[1]; ld_wdata  = rwd[1];
    end
    n_vec++;
    if (acks[0] == 0 || acks[1] == 0) begin
      n_err++; $display("FAIL rnd_fairness cpu_acks=%0d ld_acks=%0d, required both nonzero", acks[0], acks[1]);
    end
    cpu_req = 1'b0; ld_req = 1'b0;
    idle_cycles(8);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    Reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 16'h0;
    ld_req = 1'b0; ld_we = 1'b0; ld_addr = 16'h0; ld_wdata = 16'h0;
    z_cpu_req = 1'b0; z_cpu_we = 1'b0; z_cpu_addr = 16'h0; z_cpu_wdata = 16'h0;
    z_ld_req = 1'b0; z_ld_we = 1'b0; z_ld_addr = 16'h0; z_ld_wdata = 16'h0;
    z_din = 16'h0;
    ovr_en = 1'b1; ovr_val = 16'h0;
    test_reset();
    test_cpu_read();
    test_loader_write();
    test_back_to_back();
    test_input_change();
    test_reset_mid();
    test_wait0();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
